hist_cdf_builder: RTL and testbench
===================================

HIST_CDF_BUILDER -- requirements
Module: hist_cdf_builder

Interface
REQ-001 Parameter NUM_PIXELS, default 76800, is the number of pixels per frame (320x240).
REQ-002 Parameter BINS, default 256, is the number of histogram bins (8-bit luma).
REQ-003 Parameter CNT_W, default 32, is the width of the cdf and cdf_min outputs.
REQ-004 clk  in  1  is the single clock; all logic SHALL be rising-edge.
REQ-005 rst  in  1  is a synchronous, active-high reset.
REQ-006 frame_start  in  1  is a one-cycle pulse that clears the table and begins a new frame.
REQ-007 pix_valid  in  1  indicates a pixel is offered this cycle.
REQ-008 pix_in  in  8  is the pixel value.
REQ-009 pix_ready  out  1  is high only in ACCUM; a pixel is accepted when pix_valid and pix_ready are both high.
REQ-010 cdf_rd_en  in  1  requests a cdf lookup.
REQ-011 cdf_rd_addr  in  8  is the lookup bin.
REQ-012 cdf_out  out  CNT_W  is the cumulative count for the requested bin, zero-extended.
REQ-013 cdf_valid  out  1  marks cdf_out as valid.
REQ-014 cdf_min  out  CNT_W  is the smallest nonzero cdf value of the frame.
REQ-015 table_ready  out  1  is high in READY.
REQ-016 flat  out  1  is high in READY when cdf_min == NUM_PIXELS (degenerate single-value frame).

Function
REQ-017 States SHALL be CLEAR, ACCUM, SCAN and READY.
REQ-018 CLEAR: write zero to bins 0..255, one bin per cycle, for exactly 256 cycles, then go to ACCUM.
REQ-019 ACCUM: each accepted pixel increments hist[pix_in] by 1 through a 2-stage read-modify-write (read, add+write).
REQ-020 Back-to-back accepted pixels, including pixels with the same value, SHALL be forwarded so that no increment is lost; ACCUM SHALL sustain 1 pixel/cycle.
REQ-021 An internal pixel counter SHALL go to SCAN in the cycle after the NUM_PIXELS-th accepted pixel; pix_ready SHALL drop in that same cycle.
REQ-022 SCAN: read bins 0..255 in order, keep a running sum, write the sum back in place, and finish in exactly 257 cycles (256 reads + 1 drain); then go to READY.
REQ-023 cdf_min SHALL latch the first nonzero running sum during SCAN and hold it through READY.
REQ-024 READY: a cdf_rd_en asserted in cycle N gives cdf_out and cdf_valid=1 in cycle N+1; one read per cycle, fully pipelined.
REQ-025 cdf_rd_en outside READY SHALL be ignored: cdf_valid=0 and cdf_out holds its value.
REQ-026 pix_valid outside ACCUM SHALL be ignored and have no effect on the histogram.
REQ-027 frame_start in any state SHALL enter CLEAR on the next cycle and restart the clear counter at 0; in-flight increments and the scan are aborted.
REQ-028 On frame_start, cdf_min, flat and table_ready SHALL clear to 0.
REQ-029 Histogram storage SHALL be 17 bits per bin (max count 76800); cdf_out and cdf_min SHALL be zero-extended to CNT_W.
REQ-030 The final cdf[255] SHALL equal NUM_PIXELS.

Reset
REQ-031 rst SHALL force state CLEAR with the clear counter at 0, and clear the pixel counter and running sum.
REQ-032 During and after rst, pix_ready, cdf_valid, table_ready and flat SHALL be 0, and cdf_out and cdf_min SHALL be 0.
REQ-033 rst mid-ACCUM or mid-SCAN SHALL discard the partial frame; the first ACCUM cycle SHALL come 256 cycles after rst deasserts.

Structure
REQ-034 Package hist_pkg SHALL hold NUM_PIXELS, BINS, CNT_W, the bin-count width (17) and the state enum.
REQ-035 Storage SHALL be a sub-module hist_ram: 256x17 simple dual-port, synchronous read, one read port and one write port.

Verification
REQ-036 Reset, then 256 idle cycles -> pix_ready rises in cycle 257; all outputs are 0 before that.
REQ-037 Feed 76800 pixels with value = index mod 256 at 1/cycle -> every bin is 300, cdf[k] = 300*(k+1), cdf_min = 300, flat = 0.
REQ-038 Feed 76800 back-to-back pixels of value 7 -> cdf[0..6] = 0, cdf[7..255] = 76800, cdf_min = 76800, flat = 1.
REQ-039 Feed pixels with random gaps on pix_valid plus same-value bursts -> the CDF matches a reference model, and table_ready rises exactly 257 cycles after the last accept.
REQ-040 In READY, read addresses 0,255,0 on consecutive cycles -> cdf_valid is high for 3 cycles starting 1 cycle later, with the matching data.
REQ-041 Assert frame_start after 1000 accepted pixels -> pix_ready is 0 for 256 cycles, and the next full frame's CDF ignores the aborted pixels.

Source files
------------

// File: rtl/hist_pkg.sv
// Shared constants and state encodings for the histogram / CDF builder.
package hist_pkg;

    localparam int NUM_PIXELS = 76800;  // pixels per frame (320x240)
    localparam int BINS       = 256;    // one bin per 8-bit luma value
    localparam int CNT_W      = 32;     // width of cdf_out / cdf_min
    localparam int HIST_W     = 17;     // per-bin storage, holds up to 76800
    localparam int BIN_W      = 8;      // bin address width

    // Frame-level controller states
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCAN  = 2'd2,
        ST_READY = 2'd3
    } state_e;

    // What the RAM read issued last cycle was for; decides how its data is retired
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_ACC  = 2'd1,
        RD_SCAN = 2'd2,
        RD_CDF  = 2'd3
    } rd_kind_e;

endpackage

// File: rtl/hist_ram.sv
// Histogram storage: simple dual-port RAM, one synchronous read port and one
// write port. A read and a write to the same address on the same edge return
// the old contents; the controller forwards the new value itself.
module hist_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 17
) (
    input  logic          i_clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_data;

    // Write port
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port, holds its last value when not enabled
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/hist_cdf_builder.sv
// Per-frame luma histogram with in-place cumulative-sum conversion.
// Flow: CLEAR (zero all bins) -> ACCUM (count pixels) -> SCAN (prefix sum,
// written back in place) -> READY (pipelined CDF lookups).
module hist_cdf_builder #(
    parameter int NUM_PIXELS = hist_pkg::NUM_PIXELS,
    parameter int BINS       = hist_pkg::BINS,
    parameter int CNT_W      = hist_pkg::CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_frame_start,
    input  logic             i_pix_valid,
    input  logic [7:0]       i_pix_in,
    output logic             o_pix_ready,
    input  logic             i_cdf_rd_en,
    input  logic [7:0]       i_cdf_rd_addr,
    output logic [CNT_W-1:0] o_cdf_out,
    output logic             o_cdf_valid,
    output logic [CNT_W-1:0] o_cdf_min,
    output logic             o_table_ready,
    output logic             o_flat
);

    import hist_pkg::*;

    localparam int                    PIX_CNT_W  = $clog2(NUM_PIXELS + 1);
    localparam logic [PIX_CNT_W-1:0] LAST_PIX   = PIX_CNT_W'(NUM_PIXELS - 1);
    localparam logic [PIX_CNT_W-1:0] ZERO_PIX   = PIX_CNT_W'(0);
    localparam logic [PIX_CNT_W-1:0] ONE_PIX    = PIX_CNT_W'(1);
    localparam logic [BIN_W-1:0]     LAST_BIN   = BIN_W'(BINS - 1);
    localparam logic [BIN_W-1:0]     ZERO_BIN   = BIN_W'(0);
    localparam logic [BIN_W-1:0]     ONE_BIN    = BIN_W'(1);
    localparam logic [BIN_W:0]       SCAN_DRAIN = (BIN_W + 1)'(BINS);
    localparam logic [BIN_W:0]       ZERO_SCAN  = (BIN_W + 1)'(0);
    localparam logic [BIN_W:0]       ONE_SCAN   = (BIN_W + 1)'(1);
    localparam logic [HIST_W-1:0]    ZERO_HIST  = HIST_W'(0);
    localparam logic [HIST_W-1:0]    ONE_HIST   = HIST_W'(1);
    localparam logic [HIST_W-1:0]    FULL_COUNT = HIST_W'(NUM_PIXELS);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [BIN_W-1:0]      r_clr_cnt;
    logic [PIX_CNT_W-1:0]  r_pix_cnt;
    logic [BIN_W:0]        r_scan_cnt;
    rd_kind_e              r_rd_kind;
    rd_kind_e              w_rd_kind_nxt;
    logic [BIN_W-1:0]      r_rd_addr;
    logic                  r_fwd_vld;
    logic [BIN_W-1:0]      r_fwd_addr;
    logic [HIST_W-1:0]     r_fwd_data;
    logic [HIST_W-1:0]     r_sum;
    logic [HIST_W-1:0]     w_sum_nxt;
    logic [HIST_W-1:0]     r_cdf_min;
    logic [HIST_W-1:0]     w_min_nxt;
    logic                  w_flat_nxt;
    logic                  r_pix_ready;
    logic                  r_table_ready;
    logic                  r_flat;
    logic                  r_cdf_valid;
    logic [HIST_W-1:0]     r_cdf_last;

    logic                  w_accept;
    logic                  w_last_pix;
    logic                  w_rd_en;
    logic [BIN_W-1:0]      w_rd_addr;
    logic                  w_wr_en;
    logic [BIN_W-1:0]      w_wr_addr;
    logic [HIST_W-1:0]     w_wr_data;
    logic [HIST_W-1:0]     w_ram_rd_data;
    logic [HIST_W-1:0]     w_rd_data;
    logic [HIST_W-1:0]     w_scan_sum;
    logic [HIST_W-1:0]     w_cdf_sel;

    hist_ram #(
        .DEPTH (BINS),
        .AW    (BIN_W),
        .DW    (HIST_W)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ram_rd_data)
    );

    assign w_accept   = (r_state == ST_ACCUM) && i_pix_valid;
    assign w_last_pix = w_accept && (r_pix_cnt == LAST_PIX);

    // A write landing on the same edge as the read is invisible to the RAM
    // output, so take the freshly written value instead.
    assign w_rd_data  = (r_fwd_vld && (r_fwd_addr == r_rd_addr)) ? r_fwd_data : w_ram_rd_data;
    assign w_scan_sum = r_sum + w_rd_data;

    // Next-state, RAM port control, running sum and minimum tracking
    always_comb begin
        w_state_nxt   = r_state;
        w_rd_en       = 1'b0;
        w_rd_addr     = ZERO_BIN;
        w_rd_kind_nxt = RD_NONE;
        w_wr_en       = 1'b0;
        w_wr_addr     = ZERO_BIN;
        w_wr_data     = ZERO_HIST;
        w_sum_nxt     = r_sum;
        w_min_nxt     = r_cdf_min;

        if (i_frame_start) begin
            // Abort everything in flight; CLEAR rebuilds the table from scratch
            w_state_nxt = ST_CLEAR;
            w_sum_nxt   = ZERO_HIST;
            w_min_nxt   = ZERO_HIST;
        end else begin
            // Second pipeline stage: retire the read issued last cycle
            case (r_rd_kind)
                RD_ACC: begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_rd_addr;
                    w_wr_data = w_rd_data + ONE_HIST;
                end
                RD_SCAN: begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_rd_addr;
                    w_wr_data = w_scan_sum;
                    w_sum_nxt = w_scan_sum;
                    // A latched minimum is always nonzero, so zero means "not yet seen"
                    if ((r_cdf_min == ZERO_HIST) && (w_scan_sum != ZERO_HIST)) begin
                        w_min_nxt = w_scan_sum;
                    end else begin
                        w_min_nxt = r_cdf_min;
                    end
                end
                default: begin
                    w_wr_en = 1'b0;
                end
            endcase

            // First pipeline stage: issue this cycle's read / clear write
            case (r_state)
                ST_CLEAR: begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_clr_cnt;
                    w_wr_data = ZERO_HIST;
                    w_sum_nxt = ZERO_HIST;
                    if (r_clr_cnt == LAST_BIN) begin
                        w_state_nxt = ST_ACCUM;
                    end else begin
                        w_state_nxt = ST_CLEAR;
                    end
                end
                ST_ACCUM: begin
                    w_sum_nxt = ZERO_HIST;
                    if (w_accept) begin
                        w_rd_en       = 1'b1;
                        w_rd_addr     = i_pix_in;
                        w_rd_kind_nxt = RD_ACC;
                    end else begin
                        w_rd_kind_nxt = RD_NONE;
                    end
                    if (w_last_pix) begin
                        w_state_nxt = ST_SCAN;
                    end else begin
                        w_state_nxt = ST_ACCUM;
                    end
                end
                ST_SCAN: begin
                    if (r_scan_cnt < SCAN_DRAIN) begin
                        w_rd_en       = 1'b1;
                        w_rd_addr     = r_scan_cnt[BIN_W-1:0];
                        w_rd_kind_nxt = RD_SCAN;
                        w_state_nxt   = ST_SCAN;
                    end else begin
                        w_state_nxt   = ST_READY;
                    end
                end
                ST_READY: begin
                    if (i_cdf_rd_en) begin
                        w_rd_en       = 1'b1;
                        w_rd_addr     = i_cdf_rd_addr;
                        w_rd_kind_nxt = RD_CDF;
                    end else begin
                        w_rd_kind_nxt = RD_NONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_CLEAR;
                end
            endcase
        end

        w_flat_nxt = (w_state_nxt == ST_READY) && (w_min_nxt == FULL_COUNT);
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Clear address counter; wraps to 0 after the last bin
    always_ff @(posedge i_clk) begin
        if (i_rst || i_frame_start) begin
            r_clr_cnt <= ZERO_BIN;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + ONE_BIN;
        end else begin
            r_clr_cnt <= ZERO_BIN;
        end
    end

    // Accepted-pixel counter for the current frame
    always_ff @(posedge i_clk) begin
        if (i_rst || i_frame_start) begin
            r_pix_cnt <= ZERO_PIX;
        end else if (w_last_pix) begin
            r_pix_cnt <= ZERO_PIX;
        end else if (w_accept) begin
            r_pix_cnt <= r_pix_cnt + ONE_PIX;
        end else begin
            r_pix_cnt <= r_pix_cnt;
        end
    end

    // Scan cycle counter: 256 read cycles plus one drain cycle
    always_ff @(posedge i_clk) begin
        if (i_rst || i_frame_start) begin
            r_scan_cnt <= ZERO_SCAN;
        end else if (r_state == ST_SCAN) begin
            r_scan_cnt <= r_scan_cnt + ONE_SCAN;
        end else begin
            r_scan_cnt <= ZERO_SCAN;
        end
    end

    // Tag of the read in flight, consumed by the retire stage next cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_kind <= RD_NONE;
            r_rd_addr <= ZERO_BIN;
        end else begin
            r_rd_kind <= w_rd_kind_nxt;
            r_rd_addr <= w_rd_addr;
        end
    end

    // Copy of the write just committed, for read-after-write forwarding
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fwd_vld  <= 1'b0;
            r_fwd_addr <= ZERO_BIN;
            r_fwd_data <= ZERO_HIST;
        end else begin
            r_fwd_vld  <= w_wr_en;
            r_fwd_addr <= w_wr_addr;
            r_fwd_data <= w_wr_data;
        end
    end

    // Running prefix sum and first nonzero cdf value
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sum     <= ZERO_HIST;
            r_cdf_min <= ZERO_HIST;
        end else begin
            r_sum     <= w_sum_nxt;
            r_cdf_min <= w_min_nxt;
        end
    end

    // Registered status flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pix_ready   <= 1'b0;
            r_table_ready <= 1'b0;
            r_flat        <= 1'b0;
            r_cdf_valid   <= 1'b0;
        end else begin
            r_pix_ready   <= (w_state_nxt == ST_ACCUM);
            r_table_ready <= (w_state_nxt == ST_READY);
            r_flat        <= w_flat_nxt;
            r_cdf_valid   <= (w_rd_kind_nxt == RD_CDF);
        end
    end

    // Holds the last delivered lookup so cdf_out stays put between reads
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cdf_last <= ZERO_HIST;
        end else if (r_cdf_valid) begin
            r_cdf_last <= w_ram_rd_data;
        end else begin
            r_cdf_last <= r_cdf_last;
        end
    end

    // Lookups come straight off the RAM output register for one-cycle latency
    assign w_cdf_sel     = r_cdf_valid ? w_ram_rd_data : r_cdf_last;
    assign o_cdf_out     = CNT_W'(w_cdf_sel);
    assign o_cdf_valid   = r_cdf_valid;
    assign o_cdf_min     = CNT_W'(r_cdf_min);
    assign o_pix_ready   = r_pix_ready;
    assign o_table_ready = r_table_ready;
    assign o_flat        = r_flat;

endmodule

// File: tb/tb_hist_cdf_builder.sv
// Directed bench for hist_cdf_builder, run with a 1024-pixel frame.
module tb_hist_cdf_builder;

    localparam int NPIX = 1024;
    localparam int CW   = 32;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_frame_start;
    logic          i_pix_valid;
    logic [7:0]    i_pix_in;
    logic          o_pix_ready;
    logic          i_cdf_rd_en;
    logic [7:0]    i_cdf_rd_addr;
    logic [CW-1:0] o_cdf_out;
    logic          o_cdf_valid;
    logic [CW-1:0] o_cdf_min;
    logic          o_table_ready;
    logic          o_flat;

    int n_vec   = 0;
    int n_err   = 0;
    int n_stall = 0;
    int hist_m [256];
    int cdf_m  [256];

    always #5 clk = ~clk;

    hist_cdf_builder #(
        .NUM_PIXELS (NPIX),
        .BINS       (256),
        .CNT_W      (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_frame_start (i_frame_start),
        .i_pix_valid   (i_pix_valid),
        .i_pix_in      (i_pix_in),
        .o_pix_ready   (o_pix_ready),
        .i_cdf_rd_en   (i_cdf_rd_en),
        .i_cdf_rd_addr (i_cdf_rd_addr),
        .o_cdf_out     (o_cdf_out),
        .o_cdf_valid   (o_cdf_valid),
        .o_cdf_min     (o_cdf_min),
        .o_table_ready (o_table_ready),
        .o_flat        (o_flat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        foreach (hist_m[k]) hist_m[k] = 0;
    endtask

    // Offer one pixel for one cycle; the model counts it only if it is accepted
    task automatic send_pix(input logic [7:0] v);
        i_pix_valid = 1'b1;
        i_pix_in    = v;
        if (o_pix_ready) hist_m[v] += 1;
        else n_stall++;
        tick();
        i_pix_valid = 1'b0;
    endtask

    // Called right after the clearing edge: 256 cycles with no ready/valid, then ready
    task automatic wait_clear(input string tag);
        int bad;
        bad = 0;
        if (o_pix_ready || o_cdf_valid) bad++;
        repeat (255) begin
            tick();
            if (o_pix_ready || o_cdf_valid) bad++;
        end
        chk({tag, "_idle_cycles"}, bad, 0);
        tick();
        chk({tag, "_ready_rise"}, o_pix_ready, 1'b1);
    endtask

    // Called right after the last pixel edge: scan timing, min/flat, full CDF readback
    task automatic finish_frame(input string tag);
        int n;
        int acc;
        int first;
        n = 0;
        acc = 0;
        first = 0;
        chk({tag, "_no_stall"}, n_stall, 0);
        n_stall = 0;
        chk({tag, "_ready_drop"}, o_pix_ready, 1'b0);
        while (!o_table_ready && n < 400) begin
            tick();
            n++;
        end
        chk({tag, "_scan_cycles"}, n, 257);
        for (int k = 0; k < 256; k++) begin
            acc += hist_m[k];
            cdf_m[k] = acc;
            if (first == 0 && acc != 0) first = acc;
        end
        chk({tag, "_cdf_min"}, o_cdf_min, first);
        chk({tag, "_flat"}, o_flat, (first == NPIX));
        for (int k = 0; k < 256; k++) begin
            i_cdf_rd_en   = 1'b1;
            i_cdf_rd_addr = 8'(k);
            tick();
            chk($sformatf("%s_valid%0d", tag, k), o_cdf_valid, 1'b1);
            chk($sformatf("%s_cdf%0d", tag, k), o_cdf_out, cdf_m[k]);
        end
        i_cdf_rd_en = 1'b0;
        tick();
        chk({tag, "_valid_off"}, o_cdf_valid, 1'b0);
    endtask

    task automatic read_one(input string tag, input logic [7:0] a, input int exp);
        i_cdf_rd_en   = 1'b1;
        i_cdf_rd_addr = a;
        tick();
        chk({tag, "_valid"}, o_cdf_valid, 1'b1);
        chk({tag, "_data"}, o_cdf_out, exp);
    endtask

    initial begin
        int          run;
        int          gap;
        logic [7:0]  v;
        run = 0;
        gap = 0;
        v   = 8'd0;

        i_rst = 1'b1;
        i_frame_start = 1'b0;
        i_pix_valid = 1'b0;
        i_pix_in = 8'd0;
        i_cdf_rd_en = 1'b0;
        i_cdf_rd_addr = 8'd0;
        model_clear();

        // Reset state
        repeat (3) tick();
        chk("rst_pix_ready", o_pix_ready, 1'b0);
        chk("rst_cdf_valid", o_cdf_valid, 1'b0);
        chk("rst_table_ready", o_table_ready, 1'b0);
        chk("rst_flat", o_flat, 1'b0);
        chk("rst_cdf_out", o_cdf_out, 32'd0);
        chk("rst_cdf_min", o_cdf_min, 32'd0);
        i_rst = 1'b0;
        wait_clear("rst");

        // Frame A: value = index mod 256, back-to-back -> 4 per bin
        model_clear();
        for (int i = 0; i < NPIX; i++) send_pix(8'(i));
        finish_frame("fa");
        chk("fa_min_hand", o_cdf_min, 32'd4);
        chk("fa_flat_hand", o_flat, 1'b0);

        // Lookups 0,255,0 on consecutive cycles, then a hold cycle
        read_one("rd0", 8'd0, 4);
        read_one("rd255", 8'd255, 1024);
        read_one("rd0b", 8'd0, 4);
        i_cdf_rd_en = 1'b0;
        tick();
        chk("rd_idle_valid", o_cdf_valid, 1'b0);
        chk("rd_idle_hold", o_cdf_out, 32'd4);

        // Frame B: constant value 7; lookups and pixels during CLEAR are ignored
        i_frame_start = 1'b1;
        i_pix_valid = 1'b1;
        i_pix_in = 8'd200;
        tick();
        i_frame_start = 1'b0;
        chk("fs_table_ready", o_table_ready, 1'b0);
        chk("fs_cdf_min", o_cdf_min, 32'd0);
        i_cdf_rd_en = 1'b1;
        i_cdf_rd_addr = 8'd255;
        wait_clear("fb_clr");
        chk("fb_clr_hold", o_cdf_out, 32'd4);
        i_cdf_rd_en = 1'b0;
        i_pix_valid = 1'b0;
        model_clear();
        for (int i = 0; i < NPIX; i++) send_pix(8'd7);
        finish_frame("fb");
        chk("fb_min_hand", o_cdf_min, 32'd1024);
        chk("fb_flat_hand", o_flat, 1'b1);
        read_one("fb_rd6", 8'd6, 0);
        read_one("fb_rd7", 8'd7, 1024);
        i_cdf_rd_en = 1'b0;

        // Aborted frame: 1000 pixels of value 3, then frame_start mid-ACCUM
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        chk("ab_flat_clr", o_flat, 1'b0);
        chk("ab_min_clr", o_cdf_min, 32'd0);
        chk("ab_tr_clr", o_table_ready, 1'b0);
        wait_clear("ab_clr");
        for (int i = 0; i < 1000; i++) send_pix(8'd3);
        i_frame_start = 1'b1;
        i_pix_valid = 1'b1;
        i_pix_in = 8'd3;
        tick();
        i_frame_start = 1'b0;
        i_pix_valid = 1'b0;
        n_stall = 0;
        wait_clear("abort");

        // Frame C: random values in same-value bursts with random gaps; ends on bin 0
        model_clear();
        for (int i = 0; i < NPIX; i++) begin
            if (run == 0) begin
                run = int'($urandom_range(4, 1));
                v   = 8'($urandom_range(255, 0));
                gap = int'($urandom_range(3, 0));
            end else begin
                gap = 0;
            end
            if (i == NPIX - 1) v = 8'd0;
            repeat (gap) tick();
            send_pix(v);
            run--;
        end
        finish_frame("fc");

        // Reset while READY wipes the outputs and restarts clearing
        i_rst = 1'b1;
        repeat (2) tick();
        chk("rst2_table_ready", o_table_ready, 1'b0);
        chk("rst2_cdf_min", o_cdf_min, 32'd0);
        chk("rst2_cdf_out", o_cdf_out, 32'd0);
        chk("rst2_flat", o_flat, 1'b0);
        i_rst = 1'b0;
        wait_clear("rst2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
